cache_ctrl_2way: RTL and testbench

- Sequencing FSM for the 2-way set-associative cache.
- Serves CPU read/write requests and detects hit or miss from the per-way tag-compare results.
- Chooses the victim way from the LRU bit. Writes back a dirty victim, refills the line from main memory, then drives the tag-bit update strobes (valid, dirty, last-used) for the selected way.
- Sits between the CPU port, the tag/data arrays with their tag-bit update logic, and the main-memory port.

---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_burst_cnt.sv | 31 +++
 rtl/cache_ctrl_2way.sv | 190 +++++++++++++++++++
 tb/tb_cache_ctrl_2way.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the 2-way set-associative cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    REFILL,
    UPDATE
  } state_t;

  localparam logic WAY_0 = 1'b0;
  localparam logic WAY_1 = 1'b1;

  localparam int unsigned DEF_WORDS_LINE = 4;

endpackage

// File: rtl/cache_burst_cnt.sv
// Burst word counter shared by writeback and refill; returns to zero after the
// terminal word so every burst starts at word 0.
module cache_burst_cnt
  import cache_pkg::*;
#(
  parameter int unsigned WORDS_LINE = DEF_WORDS_LINE,
  parameter int unsigned WCNT_W     = $clog2(WORDS_LINE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  output logic [WCNT_W-1:0] o_cnt,
  output logic              o_last
);

  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(WORDS_LINE - 1);

  logic [WCNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_last ? '0 : r_cnt + WCNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == LAST_IDX);

endmodule

// File: rtl/cache_ctrl_2way.sv
// Sequencing FSM for the 2-way set-associative cache: lookup, writeback, refill, tag update.
// Optional hit/miss/writeback counters are built when CACHE_PERF_CNT_EN is defined.
module cache_ctrl_2way
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WORDS_LINE = DEF_WORDS_LINE,
  parameter int unsigned WCNT_W     = $clog2(WORDS_LINE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  output logic              cpu_ack,
  input  logic [1:0]        hit_way,
  input  logic [1:0]        dirty_way,
  input  logic              lru_way,
  output logic              sel_way,
  output logic              tag_we,
  output logic              set_valid,
  output logic              set_dirty,
  output logic              set_used,
  output logic              data_we,
  output logic              fill_sel,
  output logic [WCNT_W-1:0] word_idx,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_addr_sel,
  input  logic              mem_ack,
  output logic              busy
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [31:0]       wb_count
`endif
);

  if (WORDS_LINE < 2 || (WORDS_LINE & (WORDS_LINE - 1)) != 0 ||
      DATA_W == 0 || ADDR_W <= WCNT_W) begin : g_cfg_err
    $error("cache_ctrl_2way: illegal parameter set");
  end

  state_t            r_state;
  logic              r_we_q;
  logic              r_sel_way;
  logic              r_cpu_ack;

  logic              w_hit;
  logic              w_hit_sel;
  logic              w_victim_dirty;
  logic              w_burst_inc;
  logic              w_last;
  logic [WCNT_W-1:0] w_cnt;

  // hit_way=11 is illegal; the priority pick falls back to way 0
  assign w_hit          = |hit_way;
  assign w_hit_sel      = hit_way[0] ? WAY_0 : WAY_1;
  assign w_victim_dirty = dirty_way[lru_way];
  assign w_burst_inc    = mem_ack && (r_state == WRITEBACK || r_state == REFILL);

  cache_burst_cnt #(
    .WORDS_LINE(WORDS_LINE),
    .WCNT_W    (WCNT_W)
  ) u_burst_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_burst_inc),
    .o_cnt (w_cnt),
    .o_last(w_last)
  );

  // r_cpu_ack blocks re-accepting the still-asserted request in the ack cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_we_q    <= 1'b0;
      r_sel_way <= WAY_0;
      r_cpu_ack <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cpu_req && !r_cpu_ack) begin
            r_state <= LOOKUP;
            r_we_q  <= cpu_we;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_state   <= IDLE;
            r_cpu_ack <= 1'b1;
          end else begin
            r_sel_way <= lru_way;
            r_state   <= w_victim_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: if (mem_ack && w_last) r_state <= REFILL;
        REFILL:    if (mem_ack && w_last) r_state <= UPDATE;
        UPDATE: begin
          r_state   <= IDLE;
          r_cpu_ack <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sel_way      = WAY_0;
    tag_we       = 1'b0;
    set_valid    = 1'b0;
    set_dirty    = 1'b0;
    set_used     = 1'b0;
    data_we      = 1'b0;
    fill_sel     = 1'b0;
    word_idx     = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    case (r_state)
      LOOKUP: begin
        sel_way = w_hit ? w_hit_sel : lru_way;
        if (w_hit) begin
          tag_we    = 1'b1;
          set_valid = 1'b1;
          set_used  = 1'b1;
          set_dirty = r_we_q | dirty_way[w_hit_sel];
          data_we   = r_we_q;
        end
      end
      WRITEBACK: begin
        sel_way      = r_sel_way;
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr_sel = 1'b1;
        word_idx     = w_cnt;
      end
      REFILL: begin
        sel_way  = r_sel_way;
        mem_req  = 1'b1;
        word_idx = w_cnt;
        data_we  = mem_ack;
        fill_sel = mem_ack;
      end
      UPDATE: begin
        sel_way   = r_sel_way;
        tag_we    = 1'b1;
        set_valid = 1'b1;
        set_used  = 1'b1;
        set_dirty = r_we_q;
        data_we   = r_we_q;
      end
      default: ;
    endcase
  end

  assign cpu_ack = r_cpu_ack;
  assign busy    = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst && r_state == LOOKUP) begin
      assert (hit_way != 2'b11) else $error("cache_ctrl_2way: hit_way=11 in LOOKUP");
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic [31:0] r_wb_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else if (r_state == LOOKUP) begin
      if (w_hit && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 32'd1;
      if (!w_hit && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (!w_hit && w_victim_dirty && r_wb_cnt != '1) r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
  assign wb_count   = r_wb_cnt;
`endif

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed bench for cache_ctrl_2way: hits, clean/dirty misses, reset abort.
// Output bundle order: cpu_ack sel_way tag_we set_valid set_dirty set_used data_we fill_sel mem_req mem_we mem_addr_sel busy
module tb_cache_ctrl_2way;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req;
  logic       cpu_we;
  logic       cpu_ack;
  logic [1:0] hit_way;
  logic [1:0] dirty_way;
  logic       lru_way;
  logic       sel_way;
  logic       tag_we;
  logic       set_valid;
  logic       set_dirty;
  logic       set_used;
  logic       data_we;
  logic       fill_sel;
  logic [1:0] word_idx;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       mem_ack;
  logic       busy;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [31:0] wb_count;
`endif

  always #5 clk = ~clk;

  cache_ctrl_2way #(
    .ADDR_W    (16),
    .DATA_W    (32),
    .WORDS_LINE(4),
    .WCNT_W    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_ack     (cpu_ack),
    .hit_way     (hit_way),
    .dirty_way   (dirty_way),
    .lru_way     (lru_way),
    .sel_way     (sel_way),
    .tag_we      (tag_we),
    .set_valid   (set_valid),
    .set_dirty   (set_dirty),
    .set_used    (set_used),
    .data_we     (data_we),
    .fill_sel    (fill_sel),
    .word_idx    (word_idx),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr_sel(mem_addr_sel),
    .mem_ack     (mem_ack),
    .busy        (busy)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .wb_count    (wb_count)
`endif
  );

  logic [11:0] outs;
  assign outs = {cpu_ack, sel_way, tag_we, set_valid, set_dirty, set_used,
                 data_we, fill_sel, mem_req, mem_we, mem_addr_sel, busy};

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // ack cycle (request still held), then drop the request and confirm idle
  task automatic ack_then_idle(input string tag);
    cyc(); settle();
    chk({tag, "_ack"}, outs, 12'b1000_0000_0000);
    cyc(); cpu_req = 1'b0; settle();
    chk({tag, "_idle"}, outs, 12'b0000_0000_0000);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; hit_way = 2'b00;
    dirty_way = 2'b00; lru_way = 1'b0; mem_ack = 1'b0;
    cyc(); cyc(); settle();
    chk("reset_outs", outs, 12'b0000_0000_0000);
    chk("reset_widx", word_idx, 0);

    // reset during refill after two acks, then a clean retry
    cyc(); rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; hit_way = 2'b00;
    dirty_way = 2'b00; lru_way = 1'b0; mem_ack = 1'b1; settle();
    chk("abort_idle", outs, 12'b0000_0000_0000);
    cyc(); settle();
    chk("abort_lookup", outs, 12'b0000_0000_0001);
    for (int w = 0; w < 2; w++) begin
      cyc(); settle();
      chk("abort_refill", outs, 12'b0000_0011_1001);
      chk("abort_widx", word_idx, w);
    end
    cyc(); rst = 1'b1; mem_ack = 1'b0; settle();
    chk("abort_pre_rst", outs, 12'b0000_0000_1001);
    chk("abort_pre_rst_widx", word_idx, 2);
    cyc(); rst = 1'b0; cpu_req = 1'b0; settle();
    chk("abort_post_rst", outs, 12'b0000_0000_0000);
    chk("abort_post_rst_widx", word_idx, 0);
    cyc(); cpu_req = 1'b1; mem_ack = 1'b1; settle();
    cyc(); settle();
    chk("retry_lookup", outs, 12'b0000_0000_0001);
    for (int w = 0; w < 4; w++) begin
      cyc(); settle();
      chk("retry_refill", outs, 12'b0000_0011_1001);
      chk("retry_widx", word_idx, w);
    end
    cyc(); mem_ack = 1'b0; settle();
    chk("retry_update", outs, 12'b0011_0100_0001);
    ack_then_idle("retry");

    // read hit on way 0, way 0 dirty
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; hit_way = 2'b01; dirty_way = 2'b01; settle();
    chk("rdhit_idle", outs, 12'b0000_0000_0000);
    cyc(); settle();
    chk("rdhit_lookup", outs, 12'b0011_1100_0001);
    ack_then_idle("rdhit");

    // write hit on way 1
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; hit_way = 2'b10; dirty_way = 2'b00; settle();
    cyc(); settle();
    chk("wrhit_lookup", outs, 12'b0111_1110_0001);
    ack_then_idle("wrhit");

    // clean read miss, victim way 1, mem_ack every cycle
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; hit_way = 2'b00; dirty_way = 2'b00;
    lru_way = 1'b1; mem_ack = 1'b1; settle();
    cyc(); settle();
    chk("clean_lookup", outs, 12'b0100_0000_0001);
    for (int w = 0; w < 4; w++) begin
      cyc(); settle();
      chk("clean_refill", outs, 12'b0100_0011_1001);
      chk("clean_widx", word_idx, w);
    end
    cyc(); mem_ack = 1'b0; settle();
    chk("clean_update", outs, 12'b0111_0100_0001);
    ack_then_idle("clean");

    // dirty write miss, victim way 0, mem_ack every third cycle
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; hit_way = 2'b00; dirty_way = 2'b01;
    lru_way = 1'b0; mem_ack = 1'b0; settle();
    cyc(); settle();
    chk("dirty_lookup", outs, 12'b0000_0000_0001);
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 3; j++) begin
        cyc(); mem_ack = (j == 2); settle();
        chk("dirty_wb", outs, 12'b0000_0000_1111);
        chk("dirty_wb_widx", word_idx, w);
      end
    end
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 3; j++) begin
        cyc(); mem_ack = (j == 2); settle();
        chk("dirty_refill", outs, (j == 2) ? 12'b0000_0011_1001 : 12'b0000_0000_1001);
        chk("dirty_refill_widx", word_idx, w);
      end
    end
    cyc(); mem_ack = 1'b0; settle();
    chk("dirty_update", outs, 12'b0011_1110_0001);
    ack_then_idle("dirty");

    // read hit on clean way 1
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; hit_way = 2'b10; dirty_way = 2'b00; settle();
    cyc(); settle();
    chk("rdhit1_lookup", outs, 12'b0111_0100_0001);
    ack_then_idle("rdhit1");

`ifdef CACHE_PERF_CNT_EN
    chk("perf_hits", hit_count, 32'd3);
    chk("perf_misses", miss_count, 32'd3);
    chk("perf_wb", wb_count, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
